// File: rtl/mux_arb_nx1.sv
// N-to-1 channel multiplexer/arbiter with a registered output stage (fixed-select or round-robin).
// Optional registered even-parity output enabled by defining MUX_ARB_PARITY_EN.
module mux_arb_nx1 #(
    parameter  int DATA_W = 8,
    parameter  int N_CH   = 4,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic [N_CH-1:0]          valid_in,
    output logic [N_CH-1:0]          ready_in,
    input  logic [SEL_W-1:0]         selector,
    input  logic                     mode,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [SEL_W-1:0]         grant_ch
`ifdef MUX_ARB_PARITY_EN
    ,
    output logic                     parity_out
`endif
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [SEL_W-1:0]  r_grant_ch;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_accept;
    logic              w_fix_valid;
    logic              w_rr_found;
    logic [SEL_W-1:0]  w_rr_cand;
    logic [SEL_W-1:0]  w_cand;
    logic              w_grant;
    logic [DATA_W-1:0] w_cand_data;
    logic [SEL_W-1:0]  w_ptr_next;

    assign w_accept = !r_valid || ready_out;

    // An out-of-range selector matches no channel, so it can never grant.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (selector == SEL_W'(i)) begin
                w_fix_valid = valid_in[i];
            end
        end
    end

    always_comb begin
        int unsigned idx;
        w_rr_found = 1'b0;
        w_rr_cand  = '0;
        idx        = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (int'(r_ptr) + k) % N_CH;
            if (!w_rr_found && valid_in[idx]) begin
                w_rr_found = 1'b1;
                w_rr_cand  = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        w_cand  = '0;
        w_grant = 1'b0;
        if (mode) begin
            w_cand  = w_rr_cand;
            w_grant = w_rr_found && w_accept;
        end else begin
            w_cand  = selector;
            w_grant = w_fix_valid && w_accept;
        end
    end

    always_comb begin
        ready_in    = '0;
        w_cand_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_cand == SEL_W'(i)) begin
                ready_in[i] = w_grant;
                w_cand_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        if (w_cand == SEL_W'(N_CH - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_cand + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_grant_ch <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_grant) begin
                r_data     <= w_cand_data;
                r_grant_ch <= w_cand;
                r_valid    <= 1'b1;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (ready_out) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign grant_ch  = r_grant_ch;

`ifdef MUX_ARB_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_grant) begin
            r_parity <= ^w_cand_data;
        end
    end

    assign parity_out = r_parity;
`endif

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Randomised + directed bench for mux_arb_nx1 (N_CH=4, DATA_W=8) against a behavioural model.
// Parity checks are compiled in when MUX_ARB_PARITY_EN is defined.
module tb_mux_arb_nx1;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic [3:0]  valid_in;
    logic [3:0]  ready_in;
    logic [1:0]  selector;
    logic        mode;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_out;
    logic [1:0]  grant_ch;
`ifdef MUX_ARB_PARITY_EN
    logic        parity_out;
`endif

    mux_arb_nx1 #(.DATA_W(8), .N_CH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .selector  (selector),
        .mode      (mode),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .grant_ch  (grant_ch)
`ifdef MUX_ARB_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;

    logic [7:0] ch_data [4];

    // Reference model state
    int unsigned m_ptr;
    logic        m_vout;
    logic [7:0]  m_data;
    int unsigned m_ch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_vout = 1'b0;
        m_data = '0;
        m_ch   = 0;
    endtask

    task automatic check_outputs();
        check("valid_out", {31'd0, valid_out}, {31'd0, m_vout});
        check("data_out", {24'd0, data_out}, {24'd0, m_data});
        check("grant_ch", {30'd0, grant_ch}, m_ch);
`ifdef MUX_ARB_PARITY_EN
        check("parity_out", {31'd0, parity_out}, {31'd0, ^m_data});
`endif
    endtask

    // One clock: drive at negedge, check ready_in, clock, check registered outputs.
    task automatic step(input logic md, input logic [1:0] sel, input logic [3:0] vin, input logic rdy);
        bit          accept;
        bit          grant;
        int unsigned cand;
        logic [3:0]  exp_ready;
        mode      = md;
        selector  = sel;
        valid_in  = vin;
        ready_out = rdy;
        data_in   = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
        #1;
        accept = !m_vout || rdy;
        grant  = 1'b0;
        cand   = 0;
        if (!md) begin
            cand  = sel;
            grant = vin[sel] && accept;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!grant && vin[(m_ptr + k) % 4]) begin
                    cand  = (m_ptr + k) % 4;
                    grant = 1'b1;
                end
            end
            grant = grant && accept;
        end
        exp_ready = grant ? 4'(1 << cand) : 4'b0000;
        check("ready_in", {28'd0, ready_in}, {28'd0, exp_ready});
        @(posedge clk);
        if (grant) begin
            m_data = ch_data[cand];
            m_ch   = cand;
            m_vout = 1'b1;
            if (md) m_ptr = (cand + 1) % 4;
        end else if (rdy) begin
            m_vout = 1'b0;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        mode = 1'b0; selector = '0; valid_in = '0; ready_out = 1'b0; data_in = '0;
        for (int i = 0; i < 4; i++) ch_data[i] = 8'(8'h10 * (i + 1));
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        reset = 1'b1;
        @(negedge clk);

        // Fixed mode: channel 2 carries A5
        ch_data[2] = 8'hA5;
        step(1'b0, 2'd2, 4'b0100, 1'b1);
        check("fix_data", {24'd0, data_out}, 32'hA5);
        check("fix_ch", {30'd0, grant_ch}, 32'd2);

        // Mid-stream asynchronous reset with a word held
        step(1'b0, 2'd1, 4'b0010, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_ch", {30'd0, grant_ch}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Round-robin, all valid: 0,1,2,3,0,1 with no bubbles
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b1);
            check("rr_seq", {30'd0, grant_ch}, k % 4);
            check("rr_nobubble", {31'd0, valid_out}, 32'd1);
        end

        // Backpressure: hold for 3 cycles, then drain and refill together
        step(1'b0, 2'd0, 4'b0001, 1'b1);
        ch_data[0] = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd0, 4'b0001, 1'b0);
            check("bp_ready", {28'd0, ready_in}, 32'd0);
        end
        step(1'b0, 2'd0, 4'b0001, 1'b1);
        check("bp_refill", {24'd0, data_out}, 32'h3C);

        // Sparse wrap: drive ptr to 3, then only ch1 valid
        step(1'b1, 2'd0, 4'b0100, 1'b1);
        step(1'b1, 2'd0, 4'b0010, 1'b1);
        check("wrap_ch", {30'd0, grant_ch}, 32'd1);
        step(1'b1, 2'd0, 4'b0000, 1'b1);
        check("wrap_drain", {31'd0, valid_out}, 32'd0);
        step(1'b1, 2'd0, 4'b1111, 1'b1);
        check("wrap_ptr", {30'd0, grant_ch}, 32'd2);

`ifdef MUX_ARB_PARITY_EN
        ch_data[0] = 8'h07;
        step(1'b0, 2'd0, 4'b0001, 1'b1);
        check("par_07", {31'd0, parity_out}, 32'd1);
        ch_data[0] = 8'h03;
        step(1'b0, 2'd0, 4'b0001, 1'b1);
        check("par_03", {31'd0, parity_out}, 32'd0);
`endif

        // Random traffic with mode switching and backpressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) ch_data[i] = 8'($urandom);
            step(1'($urandom), 2'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
